// File: rtl/upg_pkg.sv
// upg_pkg: shared RX states, bus widths and default baud/timeout constants for the UART program loader (UPG_PARITY_EN adds even parity)
package upg_pkg;

    localparam int UPG_ADR_W        = 15;
    localparam int UPG_DAT_W        = 32;
    localparam int DEF_CLKS_PER_BIT = 87;
    localparam int DEF_IDLE_TIMEOUT = 1000000;
    localparam int DEF_MAX_WORDS    = 32768;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronised UART byte receiver, 8N1 by default, 8E1 when UPG_PARITY_EN is defined
module uart_rx_byte
    import upg_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_byte_err,
    output logic       o_idle
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_t     r_state;
    rx_state_t     w_state_nx;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_rx;
    logic          w_half;
    logic          w_full;
    logic          w_par_err;
`ifdef UPG_PARITY_EN
    logic          r_par_err;
`endif

    assign w_rx        = r_sync[1];
    assign w_half      = r_cnt == HALF_M1;
    assign w_full      = r_cnt == FULL_M1;
    assign o_byte_data = r_shift;
    assign o_idle      = r_state == RX_IDLE;
`ifdef UPG_PARITY_EN
    assign w_par_err   = r_par_err;
`else
    assign w_par_err   = 1'b0;
`endif

    // two-flop synchroniser; resets to the idle-high line level so release never looks like a start bit
    always_ff @(posedge clk) begin
        r_sync <= !rst ? 2'b11 : {r_sync[0], i_rx};
    end

    // RX state register
    always_ff @(posedge clk) begin
        r_state <= !rst ? RX_IDLE : w_state_nx;
    end

    // RX next-state: start is re-checked at half a bit, data/parity/stop are sampled at mid-bit
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            RX_IDLE:      if (!w_rx) w_state_nx = RX_START;
            RX_START:     if (w_half) w_state_nx = w_rx ? RX_IDLE : RX_DATA;
`ifdef UPG_PARITY_EN
            RX_DATA:      if (w_full && r_bit == 3'd7) w_state_nx = RX_PARITY;
            RX_PARITY:    if (w_full) w_state_nx = RX_STOP;
`else
            RX_DATA:      if (w_full && r_bit == 3'd7) w_state_nx = RX_STOP;
`endif
            RX_STOP:      if (w_full) w_state_nx = w_rx ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (w_rx) w_state_nx = RX_IDLE;
            default:      w_state_nx = RX_IDLE;
        endcase
    end

    // RX outputs: a byte is reported only at the mid-stop-bit sample
    always_comb begin
        o_byte_valid = r_state == RX_STOP && w_full && w_rx && !w_par_err;
        o_byte_err   = r_state == RX_STOP && w_full && (!w_rx || w_par_err);
    end

    // bit timer restarts on every state change and every bit period; data shifts in LSB first
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt <= (r_state == RX_IDLE || w_state_nx != r_state || w_full) ? '0 : r_cnt + 1'b1;
            if (r_state == RX_START) begin
                r_bit <= '0;
            end else if (r_state == RX_DATA && w_full) begin
                r_bit   <= r_bit + 1'b1;
                r_shift <= {w_rx, r_shift[7:1]};
            end
        end
    end

`ifdef UPG_PARITY_EN
    // even parity: data plus parity bit must carry an even number of ones; error held until the next start
    always_ff @(posedge clk) begin
        if (!rst || r_state == RX_START) begin
            r_par_err <= 1'b0;
        end else if (r_state == RX_PARITY && w_full && w_rx != ^r_shift) begin
            r_par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART boot loader packing little-endian words onto the memory upg_* port (UPG_PARITY_EN selects 8E1 frames)
module uart_prog_loader
    import upg_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
    parameter int MAX_WORDS    = DEF_MAX_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic                 upg_wen_o,
    output logic [UPG_ADR_W-1:0] upg_adr_o,
    output logic [UPG_DAT_W-1:0] upg_dat_o,
    output logic                 upg_done_o,
    output logic                 frame_err_o
);

    localparam int WCW = UPG_ADR_W + 1;
    localparam int TW  = $clog2(IDLE_TIMEOUT + 1);

    logic                 w_byte_valid;
    logic                 w_byte_err;
    logic                 w_rx_idle;
    logic [7:0]           w_byte_data;
    logic                 w_accept;
    logic                 w_counting;
    logic                 w_timeout;
    logic                 w_last;
    logic [1:0]           r_byte_cnt;
    logic [23:0]          r_word;
    logic [WCW-1:0]       r_word_cnt;
    logic [TW-1:0]        r_idle_cnt;
    logic                 r_wen;
    logic [UPG_ADR_W-1:0] r_adr;
    logic [UPG_DAT_W-1:0] r_dat;
    logic                 r_done;
    logic                 r_err;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (rx_i),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_byte_err   (w_byte_err),
        .o_idle       (w_rx_idle)
    );

    assign w_accept   = w_byte_valid && !r_done;
    assign w_counting = w_rx_idle && (r_word_cnt != '0 || r_byte_cnt != '0);
    assign w_timeout  = !r_done && w_counting && r_idle_cnt == TW'(IDLE_TIMEOUT - 1);
    assign w_last     = r_wen && r_word_cnt == WCW'(MAX_WORDS - 1);

    assign upg_wen_o   = r_wen;
    assign upg_adr_o   = r_adr;
    assign upg_dat_o   = r_dat;
    assign upg_done_o  = r_done;
    assign frame_err_o = r_err;

    // byte assembler: first three bytes are buffered, the fourth launches a one-cycle write strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_wen      <= 1'b0;
            r_adr      <= '0;
            r_dat      <= '0;
        end else begin
            r_wen <= w_accept && r_byte_cnt == 2'd3;
            if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
                if (r_byte_cnt == 2'd3) begin
                    r_dat <= {w_byte_data, r_word};
                    r_adr <= r_word_cnt[UPG_ADR_W-1:0];
                end else begin
                    r_word[{r_byte_cnt, 3'b000} +: 8] <= w_byte_data;
                end
            end else if (w_timeout) begin
                r_byte_cnt <= '0;
            end
        end
    end

    // word address advances after each strobe; idle timer restarts on every accepted byte
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_word_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            if (r_wen) r_word_cnt <= r_word_cnt + 1'b1;
            r_idle_cnt <= w_accept ? '0 : w_counting && !r_done ? r_idle_cnt + 1'b1 : r_idle_cnt;
        end
    end

    // sticky completion and error flags; a partial word at timeout counts as a framing error
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= r_done || w_timeout || w_last;
            r_err  <= r_err || (w_byte_err && !r_done) || (w_timeout && r_byte_cnt != '0);
        end
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
UART boot/program loader that sits directly upstream of the CPU memory's upgrade (upg_*) port.
- Receives a serial byte stream and assembles little-endian 32-bit words.
- Issues one-cycle write strobes with a sequential word address into program/data memory.
- Asserts a sticky done flag when loading ends. The CPU core is held until done.

Parameters:
CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz uart clock / 115200 baud).
IDLE_TIMEOUT, 1000000, idle clock cycles after the last received byte that end the transfer.
MAX_WORDS, 32768, word count that ends the transfer; must be ≤ 2^15.

Ports:
clk  in  1  single clock; the uart clock output of the clock wizard.
rst  in  1  reset; synchronous, active-low.
rx_i  in  1  UART serial input, asynchronous, idle high.
upg_wen_o  out  1  one-cycle write strobe to memory.
upg_adr_o  out  15  word address of the current write; bit 14 = 0 instruction RAM, bit 14 = 1 data RAM.
upg_dat_o  out  32  write data.
upg_done_o  out  1  load finished; sticky until reset.
frame_err_o  out  1  sticky flag: a bad stop bit, bad parity, or a partial word at timeout.

Behaviour:
- One clock, clk. Reset is synchronous and active-low: everything is cleared on a clk edge while rst = 0.
- Reset values: upg_wen_o = 0, upg_adr_o = 0, upg_dat_o = 0, upg_done_o = 0, frame_err_o = 0. All counters are 0 and the RX FSM is in IDLE.
- rx_i passes through a 2-FF synchronizer. All sampling uses the synchronized value, so there are 2 cycles of input latency.
- RX FSM:
  - IDLE → START when rx is seen low.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If low → DATA; if high → IDLE (glitch rejected).
  - DATA: sample 8 bits LSB first, each CLKS_PER_BIT cycles apart at mid-bit. Then go to PARITY (feature on) or STOP.
  - STOP: sample at mid-stop-bit. If 1, the byte is valid; if 0, the byte is dropped, frame_err_o is set, and the FSM waits for rx high before returning to IDLE.
- Byte assembler:
  - byte_cnt runs 0..3. Byte n lands in word[8n+7:8n].
  - On the 4th valid byte, upg_dat_o is loaded with the word and upg_wen_o = 1 for exactly one cycle.
  - The strobe is registered in the cycle after the stop-bit sample. upg_adr_o holds word_cnt during the strobe.
  - word_cnt increments in the cycle after the strobe. upg_adr_o and upg_dat_o hold their values between strobes.
- Idle timer:
  - Cleared on every valid byte. Counts only when word_cnt > 0 or byte_cnt > 0, and the FSM is in IDLE.
  - On reaching IDLE_TIMEOUT: upg_done_o = 1.
  - If byte_cnt ≠ 0 at that point, the partial word is discarded (no strobe) and frame_err_o = 1.
- Max words: after the strobe with word_cnt = MAX_WORDS-1, upg_done_o = 1 in the following cycle. There is no address wrap.
- After done, rx is ignored, no further strobes are issued, and outputs hold until reset.
- Reset mid-byte or mid-word: the partial data is lost. The next load starts at address 0, byte 0.
- A valid stop bit and the timeout firing in the same cycle cannot occur, because the timer counts only in IDLE.

Optional Feature:
UPG_PARITY_EN
- Defined: each frame carries an even-parity bit after bit 7, handled in a PARITY state sampled at mid-bit. On a mismatch the byte is dropped, frame_err_o is set, and the FSM still consumes the stop bit.
- Undefined: frames are 8N1, the PARITY state does not exist, and parity logic is absent.

Decomposition:
- Package upg_pkg holds:
  - RX state encoding (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - UPG_ADR_W = 15 and UPG_DAT_W = 32;
  - the default baud constants.
- Sub-module uart_rx_byte handles the synchronizer, RX FSM and parity, and outputs byte_valid, byte_data and byte_err.
- The top of uart_prog_loader holds the assembler, address counter, idle timer and done logic.

Test Plan:
All scenarios use CLKS_PER_BIT = 4 and IDLE_TIMEOUT = 64.
1. Send 0x78, 0x56, 0x34, 0x12 → single upg_wen_o pulse with adr = 0x0000 and dat = 0x12345678; frame_err_o = 0.
2. Send 8 bytes encoding 0xDEADBEEF and 0x00000013, then idle 64 cycles → strobes at adr 0 and adr 1; upg_done_o = 1; further bytes produce no strobe.
3. Force the stop bit low on byte 2 of a word → that byte is dropped and frame_err_o = 1; the next 4 valid bytes still produce a strobe (with the remaining byte_cnt alignment) and no hang.
4. Send 2 bytes, then idle → upg_done_o = 1, frame_err_o = 1, no upg_wen_o.
5. Set rst = 0 mid-way through the 3rd byte, then release and send a full word → all outputs are 0 during reset; the next strobe is at adr 0.
6. Pulse rx_i low for 1 cycle → no byte accepted and the FSM returns to IDLE. With UPG_PARITY_EN defined, a wrong parity bit → byte dropped and frame_err_o = 1.
